mips_trace_buffer: RTL and testbench
====================================

# mips_trace_buffer

Commit-trace capture FIFO that sits directly downstream of the `mips` core and consumes its `pc_out`, `instr_out` and `alu_result` outputs. Each time the core presents a new instruction, the block records one trace entry: PC, instruction word, ALU result and a sequence number. Entries are buffered in a circular FIFO and drained through a valid/ready port, so a bench monitor or debug UART can log execution without stalling the core. Overflow is flagged and counted, never back-pressured.

## Interface
- `DEPTH`, 16: number of FIFO entries; power of two, at least 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `pc_in`  in  16  core `pc_out`.
- `instr_in`  in  32  core `instr_out`.
- `alu_in`  in  16  core `alu_result`.
- `capture_en`  in  1  enables trace capture.
- `flush`  in  1  synchronous FIFO clear; does not clear `seq`, `overflow` or `drop_count`.
- `trace_valid`  out  1  head entry available.
- `trace_ready`  in  1  consumer accepts the head entry.
- `trace_pc`  out  16  head entry PC.
- `trace_instr`  out  32  head entry instruction.
- `trace_alu`  out  16  head entry ALU result.
- `trace_seq`  out  16  head entry sequence number.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: at least one capture was dropped.
- `drop_count`  out  8  number of dropped captures, saturating at 255.

## Operation
- `prev_pc` register: loads `pc_in` every cycle while not in reset. `first` flag: set by reset, cleared by the first capture attempt.
- Capture attempt in a cycle = `capture_en && (first || pc_in != prev_pc)`. A branch-to-self halt loop therefore stops producing entries.
- Every capture attempt increments the 16-bit `seq` counter, whether or not the entry is stored. `seq` wraps from 0xFFFF to 0. The entry carries the `seq` value from before the increment, so the first entry has seq 0.
- Push occurs on a capture attempt when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- Drop occurs on a capture attempt with no push. A drop sets `overflow` and increments `drop_count`, which saturates at 255.
- Pop occurs when `trace_valid && trace_ready`. `trace_ready` while empty has no effect.
- Storage: circular buffer with `ADDR_W`-bit write and read pointers that wrap modulo `DEPTH`. `count` updates by +1 on push only, −1 on pop only, and stays unchanged on simultaneous push and pop.
- `trace_*` outputs show the head entry combinationally from the read pointer (show-ahead). Their value is don't-care while `trace_valid` is 0.
- `flush` zeroes both pointers and `count`. It has priority over a push or pop in the same cycle, so any capture in a flush cycle is discarded, though not counted as a drop. `seq` still increments.
- `reset` zeroes: pointers, `count`, `seq`, `overflow`, `drop_count` and `prev_pc`, and sets `first`. It has priority over everything else.

## Timing
- Reset values: `trace_valid`=0, `count`=0, `overflow`=0, `drop_count`=0. `trace_pc`, `trace_instr`, `trace_alu` and `trace_seq` are 0 while empty after reset, because the storage RAM is zeroed by reset.
- Latency: an entry captured at rising edge N appears with `trace_valid`=1 in the cycle following edge N.
- `trace_valid` is `count != 0`.
- `overflow` and `drop_count` update at the edge of the dropping cycle.
- Reset asserted mid-drain: the next cycle shows `trace_valid`=0. The head entry presented in the reset cycle is lost even if `trace_ready` was high.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset then capture: hold `reset` 5 cycles, then drive PCs 0, 4, 8 with `capture_en`=1 and `trace_ready`=0. Required: `count`=3; head shows pc 0, seq 0. Pops then return pcs 0, 4, 8 with seqs 0, 1, 2.
- Halt dedup: hold `pc_in`=0x0010 for 10 cycles after one capture. Required: exactly one entry and `seq`=1.
- Overflow: `DEPTH`=16, 20 distinct PCs, no pops. Required: `count`=16, `overflow`=1, `drop_count`=4. Entries hold seqs 0..15, and the next attempt receives seq 20.
- Full with simultaneous pop and push: at `count`=16, `trace_ready`=1 plus a new PC. Required: `count` stays 16, no drop, and the tail holds the new PC.
- Flush and saturation: 300 drops give `drop_count`=255. A `flush` coincident with a capture gives `count`=0 and `trace_valid`=0 next cycle, with `drop_count` still 255.
- Reset mid-drain: `count`=5 and `trace_ready`=1 with `reset` asserted. Required: next cycle `count`=0, `seq`=0, `overflow`=0.

Source files
------------

// File: rtl/mips_trace_buffer_if.sv
// Trace drain port: head-entry payload plus a valid/ready handshake.
interface mips_trace_buffer_if;
    logic        trace_valid;
    logic        trace_ready;
    logic [15:0] trace_pc;
    logic [31:0] trace_instr;
    logic [15:0] trace_alu;
    logic [15:0] trace_seq;

    modport master (
        output trace_valid,
        output trace_pc,
        output trace_instr,
        output trace_alu,
        output trace_seq,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_pc,
        input  trace_instr,
        input  trace_alu,
        input  trace_seq,
        output trace_ready
    );
endinterface

// File: rtl/mips_trace_buffer.sv
// Commit-trace capture FIFO for the mips core. A new PC (or the first capture
// after reset) records one entry {pc, instr, alu, seq}. Entries drain through
// a show-ahead valid/ready port. A full FIFO never stalls the core: the
// capture is dropped, flagged sticky in overflow and counted in drop_count.
module mips_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [15:0]         pc_in,
    input  logic [31:0]         instr_in,
    input  logic [15:0]         alu_in,
    input  logic                capture_en,
    input  logic                flush,
    mips_trace_buffer_if.master trace,
    output logic [ADDR_W:0]     count,
    output logic                overflow,
    output logic [7:0]          drop_count
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);

    logic [15:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [15:0] alu_mem   [DEPTH];
    logic [15:0] seq_mem   [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [15:0]       prev_pc;
    logic [15:0]       seq;
    logic              first;

    logic attempt;
    logic full;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Capture/handshake decode; a pop frees the slot a same-cycle push needs.
    always_comb begin
        attempt = capture_en && (first || (pc_in != prev_pc));
        full    = (count == FULL_CNT);
        pop     = trace.trace_valid && trace.trace_ready;
        push    = attempt && (!full || pop);
        // A capture discarded by flush is not an overflow event.
        drop    = attempt && !push && !flush;
    end

    // Show-ahead head entry.
    assign trace.trace_valid = (count != '0);
    assign trace.trace_pc    = pc_mem[rd_ptr];
    assign trace.trace_instr = instr_mem[rd_ptr];
    assign trace.trace_alu   = alu_mem[rd_ptr];
    assign trace.trace_seq   = seq_mem[rd_ptr];

    // Control state: dedup tracking, sequence numbering, overflow, pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            prev_pc    <= '0;
            first      <= 1'b1;
        end else begin
            prev_pc <= pc_in;
            if (attempt) begin
                first <= 1'b0;
                seq   <= seq + 16'd1;
            end
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc8(drop_count);
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (push && !pop)      count <= count + CNT_ONE;
                else if (pop && !push) count <= count - CNT_ONE;
            end
        end
    end

    // Entry storage; cleared on reset so an empty buffer reads as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
                alu_mem[i]   <= '0;
                seq_mem[i]   <= '0;
            end
        end else if (push && !flush) begin
            pc_mem[wr_ptr]    <= pc_in;
            instr_mem[wr_ptr] <= instr_in;
            alu_mem[wr_ptr]   <= alu_in;
            seq_mem[wr_ptr]   <= seq;
        end
    end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Scoreboard bench for mips_trace_buffer: the driver queues each expected
// entry as it is captured; an independent monitor compares every popped head.
module tb_mips_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
        logic [15:0] alu;
        logic [15:0] seq;
    } entry_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       pc_in = '0;
    logic [31:0]       instr_in = '0;
    logic [15:0]       alu_in = '0;
    logic              capture_en = 1'b0;
    logic              flush = 1'b0;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        drop_count;

    mips_trace_buffer_if tif ();

    mips_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc_in      (pc_in),
        .instr_in   (instr_in),
        .alu_in     (alu_in),
        .capture_en (capture_en),
        .flush      (flush),
        .trace      (tif),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    entry_t      exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_count;
    logic [15:0] m_seq;
    logic [15:0] m_prev;
    logic        m_first;

    function automatic logic [31:0] mk_instr(input logic [15:0] pc);
        return {~pc, pc};
    endfunction

    function automatic logic [15:0] mk_alu(input logic [15:0] pc);
        return pc ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        capture_en = 1'b0;
        flush      = 1'b0;
        m_count    = 0;
        m_seq      = '0;
        m_prev     = '0;
        m_first    = 1'b1;
        exp_q.delete();
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One clock of stimulus; the reference bookkeeping mirrors the operation rules.
    task automatic step(input logic [15:0] pc, input logic cap, input logic rdy, input logic fl);
        logic att, pp, ps;
        entry_t e;
        pc_in            = pc;
        instr_in         = mk_instr(pc);
        alu_in           = mk_alu(pc);
        capture_en       = cap;
        tif.trace_ready  = rdy;
        flush            = fl;
        att = cap && (m_first || (pc != m_prev));
        pp  = rdy && (m_count != 0);
        ps  = att && ((m_count < DEPTH) || pp);
        if (fl) begin
            m_count = 0;
            exp_q.delete();
        end else begin
            if (ps) begin
                e.pc = pc; e.instr = mk_instr(pc); e.alu = mk_alu(pc); e.seq = m_seq;
                exp_q.push_back(e);
            end
            m_count = m_count + (ps ? 1 : 0) - (pp ? 1 : 0);
        end
        if (att) begin
            m_seq   = m_seq + 16'd1;
            m_first = 1'b0;
        end
        m_prev = pc;
        @(posedge clock);
        #1;
        flush = 1'b0;
    endtask

    // Monitor: every accepted head entry must match the scoreboard front.
    initial begin
        entry_t got, e;
        forever begin
            @(negedge clock);
            if (!reset && !flush && tif.trace_valid && tif.trace_ready) begin
                got.pc    = tif.trace_pc;
                got.instr = tif.trace_instr;
                got.alu   = tif.trace_alu;
                got.seq   = tif.trace_seq;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got pc %h seq %h, expected no entry", got.pc, got.seq);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_entry", got, e);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tif.trace_ready = 1'b0;

        // Reset state
        do_reset(5);
        chk("rst_count", 80'(count), 80'(0));
        chk("rst_valid", 80'(tif.trace_valid), 80'(0));
        chk("rst_overflow", 80'(overflow), 80'(0));
        chk("rst_drop", 80'(drop_count), 80'(0));
        chk("rst_pc", 80'(tif.trace_pc), 80'(0));
        chk("rst_seq", 80'(tif.trace_seq), 80'(0));

        // Capture PCs 0, 4, 8 then drain
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        chk("lat_valid", 80'(tif.trace_valid), 80'(1));
        step(16'h0004, 1'b1, 1'b0, 1'b0);
        step(16'h0008, 1'b1, 1'b0, 1'b0);
        chk("cap_count3", 80'(count), 80'(3));
        chk("cap_head_pc", 80'(tif.trace_pc), 80'(0));
        chk("cap_head_seq", 80'(tif.trace_seq), 80'(0));
        repeat (3) step(16'h0008, 1'b0, 1'b1, 1'b0);
        chk("drain_count", 80'(count), 80'(0));

        // Halt dedup: repeated PC yields one entry; next entry carries seq 1
        do_reset(2);
        repeat (11) step(16'h0010, 1'b1, 1'b0, 1'b0);
        chk("halt_count", 80'(count), 80'(1));
        step(16'h0014, 1'b1, 1'b0, 1'b0);
        chk("halt_count2", 80'(count), 80'(2));
        repeat (2) step(16'h0014, 1'b0, 1'b1, 1'b0);

        // Overflow: 20 distinct PCs into 16 slots
        do_reset(2);
        for (int i = 0; i < 20; i++) step(16'(i * 4), 1'b1, 1'b0, 1'b0);
        chk("ovf_count", 80'(count), 80'(16));
        chk("ovf_flag", 80'(overflow), 80'(1));
        chk("ovf_drops", 80'(drop_count), 80'(4));
        // Full with simultaneous pop and push: new entry gets seq 20
        step(16'h0100, 1'b1, 1'b1, 1'b0);
        chk("fullpp_count", 80'(count), 80'(16));
        chk("fullpp_drops", 80'(drop_count), 80'(4));
        repeat (16) step(16'h0100, 1'b0, 1'b1, 1'b0);
        chk("fullpp_drained", 80'(count), 80'(0));

        // Saturation: 16 stored then 300 drops
        do_reset(2);
        for (int i = 0; i < 316; i++) step(16'(i * 4), 1'b1, 1'b0, 1'b0);
        chk("sat_drops", 80'(drop_count), 80'(255));
        chk("sat_count", 80'(count), 80'(16));
        // Flush coincident with a capture
        step(16'h2000, 1'b1, 1'b0, 1'b1);
        chk("flush_count", 80'(count), 80'(0));
        chk("flush_valid", 80'(tif.trace_valid), 80'(0));
        chk("flush_drops", 80'(drop_count), 80'(255));
        chk("flush_ovf", 80'(overflow), 80'(1));
        // seq kept counting through the flush cycle: next entry is seq 317
        step(16'h2004, 1'b1, 1'b0, 1'b0);
        chk("postflush_seq", 80'(tif.trace_seq), 80'(317));
        step(16'h2004, 1'b0, 1'b1, 1'b0);

        // Reset mid-drain
        for (int i = 0; i < 5; i++) step(16'(16'h0400 + i * 4), 1'b1, 1'b0, 1'b0);
        chk("mid_count5", 80'(count), 80'(5));
        tif.trace_ready = 1'b1;
        do_reset(1);
        chk("mid_count", 80'(count), 80'(0));
        chk("mid_valid", 80'(tif.trace_valid), 80'(0));
        chk("mid_ovf", 80'(overflow), 80'(0));
        chk("mid_drops", 80'(drop_count), 80'(0));
        step(16'h0300, 1'b1, 1'b0, 1'b0);
        chk("mid_seq0", 80'(tif.trace_seq), 80'(0));
        step(16'h0300, 1'b0, 1'b1, 1'b0);
        chk("end_count", 80'(count), 80'(0));
        chk("end_scoreboard_empty", 80'(exp_q.size()), 80'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
